// File: rtl/alu_int_ar_flagged.sv
// Integer ALU for RV64 R-type register-register operations.
// Decode, datapath and flag generation are purely combinational from the
// inputs; only the output stage (result, flags, illegal_op, out_valid) is
// registered, giving a fixed one-cycle latency with no backpressure.

module alu_int_ar_flagged #(
  parameter int unsigned WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [WORDSIZE-1:0] input_a,
  input  logic [WORDSIZE-1:0] input_b,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  output logic [WORDSIZE-1:0] result,
  output logic [3:0]          flags,
  output logic                out_valid,
  output logic                illegal_op
);

  // Shift amount width; guarded so a 1-bit datapath still elaborates.
  localparam int unsigned ShW = (WORDSIZE > 1) ? $clog2(WORDSIZE) : 1;

  // Flag bit positions inside the flags vector.
  localparam int unsigned FlagZ = 0;
  localparam int unsigned FlagN = 1;
  localparam int unsigned FlagC = 2;
  localparam int unsigned FlagV = 3;

  typedef enum logic [3:0] {
    OpAdd,
    OpSub,
    OpSll,
    OpSlt,
    OpSltu,
    OpXor,
    OpSrl,
    OpSra,
    OpOr,
    OpAnd,
    OpIllegal
  } op_e;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------

  logic [9:0] opcode;
  op_e        op;

  assign opcode = {funct3, funct7};

  // Map {funct3,funct7} onto an internal operation; anything unlisted is illegal.
  always_comb begin
    op = OpIllegal;
    case (opcode)
      10'b000_0000000: op = OpAdd;
      10'b000_0100000: op = OpSub;
      10'b001_0000000: op = OpSll;
      10'b010_0000000: op = OpSlt;
      10'b011_0000000: op = OpSltu;
      10'b100_0000000: op = OpXor;
      10'b101_0000000: op = OpSrl;
      10'b101_0100000: op = OpSra;
      10'b110_0000000: op = OpOr;
      10'b111_0000000: op = OpAnd;
      default:         op = OpIllegal;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  logic [ShW-1:0]             shamt;
  logic [WORDSIZE:0]          add_ext;
  logic [WORDSIZE:0]          sub_ext;
  logic                       carry;
  logic                       borrow;
  logic                       a_msb;
  logic                       b_msb;
  logic                       slt_lt;
  logic signed [WORDSIZE-1:0] a_signed;
  logic [WORDSIZE-1:0]        sll_res;
  logic [WORDSIZE-1:0]        srl_res;
  logic [WORDSIZE-1:0]        sra_res;

  // Upper bits of input_b are deliberately ignored for shifts.
  assign shamt    = input_b[ShW-1:0];
  assign a_msb    = input_a[WORDSIZE-1];
  assign b_msb    = input_b[WORDSIZE-1];
  assign a_signed = input_a;

  // Shared adder/subtractor results, one bit wider to expose carry and borrow.
  always_comb begin
    add_ext = {1'b0, input_a} + {1'b0, input_b};
    sub_ext = {1'b0, input_a} - {1'b0, input_b};
    carry   = add_ext[WORDSIZE];
    // Top bit of the widened difference is set exactly when a < b unsigned.
    borrow  = sub_ext[WORDSIZE];
  end

  // Signed less-than reuses the borrow: differing signs decide by a's sign,
  // equal signs compare like unsigned.
  always_comb begin
    slt_lt = (a_msb != b_msb) ? a_msb : borrow;
  end

  // Barrel shifts.
  always_comb begin
    sll_res = input_a << shamt;
    srl_res = input_a >> shamt;
    sra_res = WORDSIZE'($unsigned(a_signed >>> shamt));
  end

  // ---------------------------------------------------------------------------
  // Result and flag generation
  // ---------------------------------------------------------------------------

  logic [WORDSIZE-1:0] result_d;
  logic [3:0]          flags_d;
  logic                illegal_d;
  logic                flag_c;
  logic                flag_v;

  // Select the operation result; C and V only meaningful for ADD/SUB.
  always_comb begin
    result_d  = '0;
    illegal_d = 1'b0;
    flag_c    = 1'b0;
    flag_v    = 1'b0;
    unique case (op)
      OpAdd: begin
        result_d = add_ext[WORDSIZE-1:0];
        flag_c   = carry;
        flag_v   = (a_msb == b_msb) && (add_ext[WORDSIZE-1] != a_msb);
      end
      OpSub: begin
        result_d = sub_ext[WORDSIZE-1:0];
        flag_c   = borrow;
        flag_v   = (a_msb != b_msb) && (sub_ext[WORDSIZE-1] != a_msb);
      end
      OpSll:  result_d = sll_res;
      OpSlt:  result_d = WORDSIZE'(slt_lt);
      OpSltu: result_d = WORDSIZE'(borrow);
      OpXor:  result_d = input_a ^ input_b;
      OpSrl:  result_d = srl_res;
      OpSra:  result_d = sra_res;
      OpOr:   result_d = input_a | input_b;
      OpAnd:  result_d = input_a & input_b;
      OpIllegal: begin
        result_d  = '0;
        illegal_d = 1'b1;
      end
      default: begin
        result_d  = '0;
        illegal_d = 1'b1;
      end
    endcase
  end

  // Z and N follow the selected result for every operation, illegal included.
  always_comb begin
    flags_d        = 4'b0000;
    flags_d[FlagZ] = (result_d == '0);
    flags_d[FlagN] = result_d[WORDSIZE-1];
    flags_d[FlagC] = flag_c;
    flags_d[FlagV] = flag_v;
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------

  logic [WORDSIZE-1:0] result_q;
  logic [3:0]          flags_q;
  logic                illegal_q;
  logic                valid_q;

  // Capture on in_valid, otherwise hold data and drop valid; reset clears all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      flags_q   <= 4'b0000;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q  <= result_d;
        flags_q   <= flags_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign result     = result_q;
  assign flags      = flags_q;
  assign illegal_op = illegal_q;
  assign out_valid  = valid_q;

endmodule

// File: tb/tb_alu_int_ar_flagged.sv
// Self-checking bench for alu_int_ar_flagged (WORDSIZE = 64).
// Expected outputs are queued as each operation is driven and popped one
// clock later when the registered result appears.

module tb_alu_int_ar_flagged;

  localparam int unsigned W = 64;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   flg;
    logic         ill;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] input_a = '0;
  logic [W-1:0] input_b = '0;
  logic [2:0]   funct3 = '0;
  logic [6:0]   funct7 = '0;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         out_valid;
  logic         illegal_op;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_int_ar_flagged #(
    .WORDSIZE(W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .input_a   (input_a),
    .input_b   (input_b),
    .funct3    (funct3),
    .funct7    (funct7),
    .result    (result),
    .flags     (flags),
    .out_valid (out_valid),
    .illegal_op(illegal_op)
  );

  // Reference model for random traffic; flags packed as {V,C,N,Z}.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] f3, input logic [6:0] f7);
    exp_t         e;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         ill;
    int           sh;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    ill = 1'b0;
    sh  = int'(b[5:0]);
    case ({f3, f7})
      {3'd0, 7'h00}: begin
        r = a + b;
        c = (r < a);
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      {3'd0, 7'h20}: begin
        r = a - b;
        c = (a < b);
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      {3'd1, 7'h00}: r = a << sh;
      {3'd2, 7'h00}: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      {3'd3, 7'h00}: r = (a < b) ? 64'd1 : 64'd0;
      {3'd4, 7'h00}: r = a ^ b;
      {3'd5, 7'h00}: r = a >> sh;
      {3'd5, 7'h20}: begin
        r = a >> sh;
        if (a[63]) r = r | ~(64'hFFFF_FFFF_FFFF_FFFF >> sh);
      end
      {3'd6, 7'h00}: r = a | b;
      {3'd7, 7'h00}: r = a & b;
      default: begin
        r   = '0;
        ill = 1'b1;
      end
    endcase
    e.res = r;
    e.flg = {v, c, r[63], (r == 64'd0)};
    e.ill = ill;
    return e;
  endfunction

  // Present one operation and queue what it must produce.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f3,
                       input logic [6:0] f7, input exp_t e);
    input_a  = a;
    input_b  = b;
    funct3   = f3;
    funct7   = f7;
    in_valid = 1'b1;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (result !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_result: got %h want 0", result);
    end
    n_cmp++;
    if (flags !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000", flags);
    end
    n_cmp++;
    if (illegal_op !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_illegal: got %b want 0", illegal_op);
    end
    // An operation presented while reset is held must be ignored.
    input_a  = 64'd5;
    input_b  = 64'd3;
    funct3   = 3'd0;
    funct7   = 7'h00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || result !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_discard: got v=%b r=%h want v=0 r=0", out_valid, result);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_idle: got v=%b want 0", out_valid);
    end
  endtask

  // Run a directed list of operations back to back, one check per cycle.
  task automatic run_list(input string nm, input int n, input logic [W-1:0] av[8],
                          input logic [W-1:0] bv[8], input logic [2:0] f3v[8],
                          input logic [6:0] f7v[8], input exp_t ev[8]);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      drive(av[i], bv[i], f3v[i], f7v[i], ev[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || result !== e.res || flags !== e.flg || illegal_op !== e.ill) begin
        n_bad++;
        $display("FAIL %s[%0d]: got v=%b r=%h f=%b ill=%b, want v=1 r=%h f=%b ill=%b", nm, i,
                 out_valid, result, flags, illegal_op, e.res, e.flg, e.ill);
      end
    end
  endtask

  task automatic test_add_sub();
    logic [W-1:0] av[8];
    logic [W-1:0] bv[8];
    logic [2:0]   f3v[8];
    logic [6:0]   f7v[8];
    exp_t         ev[8];
    av  = '{64'd5, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd5,
            64'h8000_0000_0000_0000, 0, 0};
    bv  = '{64'd3, 64'd1, 64'd1, 64'd5, 64'd3, 64'd1, 0, 0};
    f3v = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 0, 0};
    f7v = '{7'h00, 7'h00, 7'h00, 7'h20, 7'h20, 7'h20, 0, 0};
    ev  = '{'{64'd8, 4'b0000, 1'b0},
            '{64'h8000_0000_0000_0000, 4'b1010, 1'b0},
            '{64'd0, 4'b0101, 1'b0},
            '{64'hFFFF_FFFF_FFFF_FFFE, 4'b0110, 1'b0},
            '{64'd2, 4'b0000, 1'b0},
            '{64'h7FFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0},
            '{64'd0, 4'b0000, 1'b0}, '{64'd0, 4'b0000, 1'b0}};
    run_list("add_sub", 6, av, bv, f3v, f7v, ev);
  endtask

  task automatic test_shift_compare();
    logic [W-1:0] av[8];
    logic [W-1:0] bv[8];
    logic [2:0]   f3v[8];
    logic [6:0]   f7v[8];
    exp_t         ev[8];
    av  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd1, 64'd1,
            64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0};
    bv  = '{64'd63, 64'd63, 64'd64, 64'd63, 64'd1, 64'd1, 0, 0};
    f3v = '{3'd5, 3'd5, 3'd1, 3'd1, 3'd2, 3'd3, 0, 0};
    f7v = '{7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 0, 0};
    ev  = '{'{64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 1'b0},
            '{64'd1, 4'b0000, 1'b0},
            '{64'd1, 4'b0000, 1'b0},
            '{64'h8000_0000_0000_0000, 4'b0010, 1'b0},
            '{64'd1, 4'b0000, 1'b0},
            '{64'd0, 4'b0001, 1'b0},
            '{64'd0, 4'b0000, 1'b0}, '{64'd0, 4'b0000, 1'b0}};
    run_list("shift_cmp", 6, av, bv, f3v, f7v, ev);
  endtask

  task automatic test_logic();
    logic [W-1:0] av[8];
    logic [W-1:0] bv[8];
    logic [2:0]   f3v[8];
    logic [6:0]   f7v[8];
    exp_t         ev[8];
    av  = '{64'hF0F0_F0F0_F0F0_F0F0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hF0F0_F0F0_F0F0_F0F0,
            64'h1234, 0, 0, 0, 0};
    bv  = '{64'hFF00_FF00_FF00_FF00, 64'hFF00_FF00_FF00_FF00, 64'hFF00_FF00_FF00_FF00,
            64'h1234, 0, 0, 0, 0};
    f3v = '{3'd4, 3'd6, 3'd7, 3'd4, 0, 0, 0, 0};
    f7v = '{7'h00, 7'h00, 7'h00, 7'h00, 0, 0, 0, 0};
    ev  = '{'{64'h0FF0_0FF0_0FF0_0FF0, 4'b0000, 1'b0},
            '{64'hFFF0_FFF0_FFF0_FFF0, 4'b0010, 1'b0},
            '{64'hF000_F000_F000_F000, 4'b0010, 1'b0},
            '{64'd0, 4'b0001, 1'b0},
            '{64'd0, 4'b0000, 1'b0}, '{64'd0, 4'b0000, 1'b0},
            '{64'd0, 4'b0000, 1'b0}, '{64'd0, 4'b0000, 1'b0}};
    run_list("logic", 4, av, bv, f3v, f7v, ev);
  endtask

  task automatic test_illegal_hold();
    logic [W-1:0] av[8];
    logic [W-1:0] bv[8];
    logic [2:0]   f3v[8];
    logic [6:0]   f7v[8];
    exp_t         ev[8];
    // ADD 5+3 with nonzero result, then two illegal codes, last one held.
    av  = '{64'd5, 64'd7, 64'd9, 0, 0, 0, 0, 0};
    bv  = '{64'd3, 64'd2, 64'd4, 0, 0, 0, 0, 0};
    f3v = '{3'd0, 3'd1, 3'd0, 0, 0, 0, 0, 0};
    f7v = '{7'h00, 7'h20, 7'h01, 0, 0, 0, 0, 0};
    ev  = '{'{64'd8, 4'b0000, 1'b0},
            '{64'd0, 4'b0001, 1'b1},
            '{64'd0, 4'b0001, 1'b1},
            '{64'd0, 4'b0000, 1'b0}, '{64'd0, 4'b0000, 1'b0},
            '{64'd0, 4'b0000, 1'b0}, '{64'd0, 4'b0000, 1'b0}, '{64'd0, 4'b0000, 1'b0}};
    run_list("illegal", 3, av, bv, f3v, f7v, ev);
    // Idle cycle with fresh legal operands on the bus: outputs must hold.
    input_a  = 64'd5;
    input_b  = 64'd3;
    funct3   = 3'd0;
    funct7   = 7'h00;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || result !== 64'd0 || flags !== 4'b0001 || illegal_op !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_hold: got v=%b r=%h f=%b ill=%b, want v=0 r=0 f=0001 ill=1",
               out_valid, result, flags, illegal_op);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]   f3t[11];
    logic [6:0]   f7t[11];
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
    int           k;
    f3t = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd0};
    f7t = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 7'h01};
    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 10));
      case ($urandom_range(0, 4))
        0:       a = 64'h8000_0000_0000_0000;
        1:       a = 64'hFFFF_FFFF_FFFF_FFFF;
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 4))
        0:       b = 64'd1;
        1:       b = a;
        default: b = {$urandom, $urandom};
      endcase
      if (k == 10) f3t[10] = 3'($urandom_range(0, 7));
      drive(a, b, f3t[k], f7t[k], model(a, b, f3t[k], f7t[k]));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || result !== e.res || flags !== e.flg || illegal_op !== e.ill) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got v=%b r=%h f=%b ill=%b, want v=1 r=%h f=%b ill=%b", i,
                 out_valid, result, flags, illegal_op, e.res, e.flg, e.ill);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    drive(64'd5, 64'd3, 3'd0, 7'h00, '{64'd8, 4'b0000, 1'b0});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || result !== e.res || flags !== e.flg) begin
      n_bad++;
      $display("FAIL mid_pre: got v=%b r=%h f=%b, want v=1 r=%h f=%b", out_valid, result, flags,
               e.res, e.flg);
    end
    // Next op is in flight when reset hits between edges.
    input_a  = 64'd3;
    input_b  = 64'd5;
    funct7   = 7'h20;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || result !== 64'd0 || flags !== 4'b0000 || illegal_op !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got v=%b r=%h f=%b ill=%b, want all 0", out_valid, result, flags,
               illegal_op);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || result !== 64'd0) begin
      n_bad++;
      $display("FAIL mid_discard: got v=%b r=%h want v=0 r=0", out_valid, result);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    drive(64'd1, 64'd1, 3'd0, 7'h00, '{64'd2, 4'b0000, 1'b0});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || result !== e.res || flags !== e.flg || illegal_op !== e.ill) begin
      n_bad++;
      $display("FAIL mid_after: got v=%b r=%h f=%b want v=1 r=%h f=%b", out_valid, result, flags,
               e.res, e.flg);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_shift_compare();
    test_logic();
    test_illegal_hold();
    test_back_to_back();
    test_reset_midstream();
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
